ecg_hybrid_decoder: RTL and testbench

ECG_HYBRID_DECODER -- requirements
Module: ecg_hybrid_decoder

---
 rtl/ecg_hybrid_decoder_pkg.sv | 61 ++++++
 rtl/ecg_hybrid_decoder_grc_delta.sv | 43 ++++
 rtl/ecg_hybrid_decoder.sv | 209 ++++++++++++++++++++
 tb/tb_ecg_hybrid_decoder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecg_hybrid_decoder_pkg.sv
// ecg_hybrid_decoder_pkg
// Shared definitions for the hybrid RLC/GRC ECG decoder: token-type encoding,
// in_data field positions, the k-code map (decoder and encoder direction) and
// the decoder FSM state type.
package ecg_hybrid_decoder_pkg;

  localparam int DATA_W    = 12;  // token payload width
  localparam int DELTA_W   = 18;  // GRC delta arithmetic width (signed)

  // in_data field positions
  localparam int KCODE_MSB = 11;
  localparam int KCODE_LSB = 10;
  localparam int Q_MSB     = 9;
  localparam int Q_LSB     = 6;
  localparam int R_MSB     = 5;
  localparam int R_LSB     = 0;
  localparam int RUN_MSB   = 5;
  localparam int RUN_LSB   = 0;

  // token type encoding
  localparam logic TOK_RLC = 1'b0;
  localparam logic TOK_GRC = 1'b1;

  // k-code map
  localparam logic [1:0] KCODE_BAD = 2'b00;
  localparam logic [1:0] KCODE_K3  = 2'b01;
  localparam logic [1:0] KCODE_K4  = 2'b10;
  localparam logic [1:0] KCODE_K5  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_TOK = 2'b01,
    ST_RUN_EMIT = 2'b10,
    ST_GRC_EMIT = 2'b11
  } state_e;

  // decoder direction: k code -> shift amount (0 for the illegal code)
  function automatic logic [2:0] kcode_to_k(input logic [1:0] kcode);
    logic [2:0] k;
    case (kcode)
      KCODE_K3: k = 3'd3;
      KCODE_K4: k = 3'd4;
      KCODE_K5: k = 3'd5;
      default:  k = 3'd0;
    endcase
    return k;
  endfunction

  // encoder direction: shift amount -> k code (KCODE_BAD if not encodable)
  function automatic logic [1:0] k_to_kcode(input logic [2:0] k);
    logic [1:0] kcode;
    case (k)
      3'd3:    kcode = KCODE_K3;
      3'd4:    kcode = KCODE_K4;
      3'd5:    kcode = KCODE_K5;
      default: kcode = KCODE_BAD;
    endcase
    return kcode;
  endfunction

endpackage

// File: rtl/ecg_hybrid_decoder_grc_delta.sv
// ecg_grc_delta
// Combinational GRC token decode: delta = ((q <<< k) + r) <<< k at DELTA_W
// bits signed. r is the low k+1 bits of the r field, sign-extended.
// Ports:
//   i_data      token payload (k code, signed q, signed r)
//   o_delta     signed decoded delta
//   o_kcode_ok  0 when the k code is the illegal 00 value
module ecg_grc_delta
  import ecg_hybrid_decoder_pkg::*;
(
  input  logic [DATA_W-1:0]         i_data,
  output logic signed [DELTA_W-1:0] o_delta,
  output logic                      o_kcode_ok
);

  logic [1:0]                w_kcode;
  logic [2:0]                w_k;
  logic [5:0]                w_r_field;
  logic signed [DELTA_W-1:0] w_q;
  logic signed [DELTA_W-1:0] w_r;
  logic signed [DELTA_W-1:0] w_mid;

  assign w_kcode    = i_data[KCODE_MSB:KCODE_LSB];
  assign w_k        = kcode_to_k(w_kcode);
  assign o_kcode_ok = (w_kcode != KCODE_BAD);
  assign w_r_field  = i_data[R_MSB:R_LSB];
  assign w_q        = {{(DELTA_W-4){i_data[Q_MSB]}}, i_data[Q_MSB:Q_LSB]};

  // Select the k+1 low bits of the r field and sign-extend them
  always_comb begin
    w_r = {DELTA_W{1'b0}};
    case (w_k)
      3'd3:    w_r = {{(DELTA_W-4){w_r_field[3]}}, w_r_field[3:0]};
      3'd4:    w_r = {{(DELTA_W-5){w_r_field[4]}}, w_r_field[4:0]};
      3'd5:    w_r = {{(DELTA_W-6){w_r_field[5]}}, w_r_field[5:0]};
      default: w_r = {DELTA_W{1'b0}};
    endcase
  end

  assign w_mid   = (w_q <<< w_k) + w_r;
  assign o_delta = w_mid <<< w_k;

endmodule

// File: rtl/ecg_hybrid_decoder.sv
// ecg_hybrid_decoder
// Reconstructs ECG samples from a baseline plus a stream of RLC run tokens
// (repeat the predictor) and GRC tokens (predictor + decoded delta, saturated).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   base_valid, base           load predictor / start a new frame
//   in_valid/in_ready          token handshake; in_type selects RLC (0) / GRC (1)
//   in_data                    token payload
//   out_valid/out_ready        sample handshake; out_sample, out_index
//   frame_done                 pulse when the last sample of a frame is accepted
//   err                        sticky protocol error, cleared by base_valid
module ecg_hybrid_decoder
  import ecg_hybrid_decoder_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int SAMPLE_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         base_valid,
  input  logic signed [SAMPLE_W-1:0]   base,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_type,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [SAMPLE_W-1:0]   out_sample,
  output logic [$clog2(FRAME_LEN)-1:0] out_index,
  output logic                         frame_done,
  output logic                         err
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int CNT_W = 7;  // holds run counts up to 63 and frame sizes up to 32
  localparam int SUM_W = SAMPLE_W + DELTA_W;

  state_e                     r_state, w_nxt_state;
  logic signed [SAMPLE_W-1:0] r_pred, w_nxt_pred;
  logic [IDX_W-1:0]           r_idx, w_nxt_idx;          // index of the next sample to load
  logic [5:0]                 r_run_cnt, w_nxt_run_cnt;  // run samples still to load
  logic                       r_out_valid, w_nxt_out_valid;
  logic signed [SAMPLE_W-1:0] r_out_sample, w_nxt_out_sample;
  logic [IDX_W-1:0]           r_out_index, w_nxt_out_index;
  logic                       r_err, w_nxt_err;

  logic signed [DELTA_W-1:0]  w_delta;
  logic                       w_kcode_ok;
  logic signed [SUM_W-1:0]    w_sum, w_max, w_min;
  logic signed [SAMPLE_W-1:0] w_sat;
  logic [CNT_W-1:0]           w_rem, w_run_len, w_emit_len;
  logic                       w_in_ready, w_out_fire, w_tok_fire;

  ecg_grc_delta u_grc_delta (
    .i_data     (in_data),
    .o_delta    (w_delta),
    .o_kcode_ok (w_kcode_ok)
  );

  assign w_sum = {{(SUM_W-SAMPLE_W){r_pred[SAMPLE_W-1]}}, r_pred}
               + {{(SUM_W-DELTA_W){w_delta[DELTA_W-1]}}, w_delta};
  assign w_max = {{(SUM_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  assign w_min = {{(SUM_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};
  assign w_sat = (w_sum > w_max) ? w_max[SAMPLE_W-1:0] :
                 (w_sum < w_min) ? w_min[SAMPLE_W-1:0] : w_sum[SAMPLE_W-1:0];

  // A run never crosses a frame boundary: clip it to the samples left in this frame
  assign w_rem      = CNT_W'(FRAME_LEN) - CNT_W'(r_idx);
  assign w_run_len  = {1'b0, in_data[RUN_MSB:RUN_LSB]};
  assign w_emit_len = (w_run_len > w_rem) ? w_rem : w_run_len;

  assign w_out_fire = r_out_valid && out_ready;
  assign w_tok_fire = in_valid && w_in_ready;

  // Next-state and datapath update
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_pred       = r_pred;
    w_nxt_idx        = r_idx;
    w_nxt_run_cnt    = r_run_cnt;
    w_nxt_out_valid  = r_out_valid;
    w_nxt_out_sample = r_out_sample;
    w_nxt_out_index  = r_out_index;
    w_nxt_err        = r_err;
    w_in_ready       = 1'b0;
    if (base_valid) begin
      // baseline wins over everything, including a token offered this cycle
      w_nxt_state     = ST_WAIT_TOK;
      w_nxt_pred      = base;
      w_nxt_idx       = {IDX_W{1'b0}};
      w_nxt_run_cnt   = 6'd0;
      w_nxt_out_valid = 1'b0;
      w_nxt_out_index = {IDX_W{1'b0}};
      w_nxt_err       = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_nxt_state = ST_IDLE;
        end
        ST_WAIT_TOK: begin
          w_in_ready = !r_out_valid || out_ready;
          if (w_tok_fire) begin
            case (in_type)
              TOK_GRC: begin
                if (w_kcode_ok) begin
                  w_nxt_pred       = w_sat;
                  w_nxt_out_valid  = 1'b1;
                  w_nxt_out_sample = w_sat;
                  w_nxt_out_index  = r_idx;
                  w_nxt_idx        = r_idx + IDX_W'(1);
                  w_nxt_state      = ST_GRC_EMIT;
                end else begin
                  w_nxt_err = 1'b1;
                end
              end
              TOK_RLC: begin
                if (w_run_len == {CNT_W{1'b0}}) begin
                  w_nxt_err = 1'b1;
                end else begin
                  if (w_run_len > w_rem) begin
                    w_nxt_err = 1'b1;
                  end else begin
                    w_nxt_err = r_err;
                  end
                  w_nxt_out_valid  = 1'b1;
                  w_nxt_out_sample = r_pred;
                  w_nxt_out_index  = r_idx;
                  w_nxt_idx        = r_idx + IDX_W'(1);
                  w_nxt_run_cnt    = 6'(w_emit_len - 7'd1);
                  w_nxt_state      = ST_RUN_EMIT;
                end
              end
              default: begin
                w_nxt_err = 1'b1;
              end
            endcase
          end else begin
            w_nxt_state = ST_WAIT_TOK;
          end
        end
        ST_RUN_EMIT: begin
          if (w_out_fire) begin
            if (r_run_cnt != 6'd0) begin
              w_nxt_out_sample = r_pred;
              w_nxt_out_index  = r_idx;
              w_nxt_idx        = r_idx + IDX_W'(1);
              w_nxt_run_cnt    = r_run_cnt - 6'd1;
            end else begin
              w_nxt_out_valid = 1'b0;
              w_nxt_state     = ST_WAIT_TOK;
            end
          end else begin
            w_nxt_state = ST_RUN_EMIT;
          end
        end
        ST_GRC_EMIT: begin
          if (w_out_fire) begin
            w_nxt_out_valid = 1'b0;
            w_nxt_state     = ST_WAIT_TOK;
          end else begin
            w_nxt_state = ST_GRC_EMIT;
          end
        end
        default: begin
          w_nxt_state     = ST_IDLE;
          w_nxt_out_valid = 1'b0;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // Predictor, run counter, output and error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred       <= {SAMPLE_W{1'b0}};
      r_idx        <= {IDX_W{1'b0}};
      r_run_cnt    <= 6'd0;
      r_out_valid  <= 1'b0;
      r_out_sample <= {SAMPLE_W{1'b0}};
      r_out_index  <= {IDX_W{1'b0}};
      r_err        <= 1'b0;
    end else begin
      r_pred       <= w_nxt_pred;
      r_idx        <= w_nxt_idx;
      r_run_cnt    <= w_nxt_run_cnt;
      r_out_valid  <= w_nxt_out_valid;
      r_out_sample <= w_nxt_out_sample;
      r_out_index  <= w_nxt_out_index;
      r_err        <= w_nxt_err;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_sample = r_out_sample;
  assign out_index  = r_out_index;
  assign err        = r_err;
  assign frame_done = w_out_fire && (r_out_index == IDX_W'(FRAME_LEN - 1));

endmodule

// File: tb/tb_ecg_hybrid_decoder.sv
// tb_ecg_hybrid_decoder
// Directed stimulus with hand-computed expected samples pushed to a scoreboard
// queue; a negedge monitor pops and compares on every accepted output sample.
module tb_ecg_hybrid_decoder;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               base_valid;
  logic signed [15:0] base;
  logic               in_valid;
  logic               in_ready;
  logic               in_type;
  logic [11:0]        in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_sample;
  logic [2:0]         out_index;
  logic               frame_done;
  logic               err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic signed [15:0] s;
    logic [2:0]         i;
    logic               fd;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  ecg_hybrid_decoder #(.FRAME_LEN(8), .SAMPLE_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .base_valid (base_valid),
    .base       (base),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_type    (in_type),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .out_index  (out_index),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic logic [11:0] grc(input logic [1:0] kc, input logic [3:0] q, input logic [5:0] r);
    return {kc, q, r};
  endfunction

  function automatic logic [11:0] run(input int n);
    logic [5:0] c;
    c = n[5:0];
    return {6'd0, c};
  endfunction

  task automatic push(input int s, input int i, input int fd);
    exp_t e;
    e.s  = s[15:0];
    e.i  = i[2:0];
    e.fd = fd[0];
    sb_q.push_back(e);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic load_base(input int v);
    base_valid = 1'b1;
    base       = v[15:0];
    sync();
    base_valid = 1'b0;
  endtask

  // offer a token, wait (bounded) for acceptance, then check first-output latency
  task automatic send_tok(input logic typ, input logic [11:0] data, input int exp_out);
    bit ok;
    int n;
    in_valid = 1'b1;
    in_type  = typ;
    in_data  = data;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else sync();
      n++;
    end
    if (ok) begin
      sync();
      in_valid = 1'b0;
      @(negedge clk);
      chk("latency_out_valid", out_valid, exp_out);
      sync();
    end else begin
      in_valid = 1'b0;
      chk("tok_accept_timeout", 0, 1);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("drain_timeout", 1, 0);
    sync();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_sample", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sample", int'(out_sample), int'(mon_e.s));
        chk("index", int'(out_index), int'(mon_e.i));
        chk("frame_done", int'(frame_done), int'(mon_e.fd));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; base_valid = 1'b0; base = 16'sd0; in_valid = 1'b0;
    in_type = 1'b0; in_data = 12'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sample", int'(out_sample), 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    // IDLE ignores tokens until a baseline arrives
    in_valid = 1'b1; in_type = 1'b1; in_data = grc(2'b01, 4'd2, 6'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_in_ready", in_ready, 0);
      chk("idle_out_valid", out_valid, 0);
      sync();
    end
    in_valid = 1'b0;

    // base 1000, GRC k=3 q=2 r=1 -> 1136, then a run of 3
    load_base(1000);
    push(1136, 0, 0);
    send_tok(1'b1, grc(2'b01, 4'd2, 6'd1), 1);
    for (int i = 1; i <= 3; i++) push(1136, i, 0);
    send_tok(1'b0, run(3), 1);
    @(negedge clk); chk("run_consec_2", out_valid, 1);
    @(negedge clk); chk("run_consec_3", out_valid, 1);
    @(negedge clk); chk("run_end", out_valid, 0);
    sync();

    // illegal k code and zero run both set err and emit nothing
    load_base(5);
    chk("err_cleared_a", err, 0);
    send_tok(1'b1, grc(2'b00, 4'd1, 6'd1), 0);
    chk("err_kcode00", err, 1);
    load_base(5);
    chk("err_cleared_b", err, 0);
    send_tok(1'b0, run(0), 0);
    chk("err_run0", err, 1);

    // saturation both ways
    load_base(32000);
    push(32767, 0, 0);
    send_tok(1'b1, grc(2'b11, 4'd7, 6'd31), 1);
    load_base(-32000);
    push(-32768, 0, 0);
    send_tok(1'b1, grc(2'b11, 4'b1000, 6'd0), 1);

    // run of 10 at index 2 is truncated to 6 samples at the frame end
    load_base(50);
    push(66, 0, 0);
    send_tok(1'b1, grc(2'b01, 4'd0, 6'd2), 1);
    push(66, 1, 0);
    send_tok(1'b1, grc(2'b01, 4'd0, 6'd0), 1);
    chk("err_before_trunc", err, 0);
    for (int i = 2; i <= 7; i++) push(66, i, (i == 7) ? 1 : 0);
    send_tok(1'b0, run(10), 1);
    wait_idle();
    chk("err_trunc", err, 1);
    // k=4 q=1 r=-1 -> 240; predictor carries across the frame
    push(306, 0, 0);
    send_tok(1'b1, grc(2'b10, 4'd1, 6'h3F), 1);

    // stall mid-run: sample/index hold and no token is taken
    load_base(7);
    for (int i = 0; i < 6; i++) push(7, i, 0);
    send_tok(1'b0, run(6), 1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_index", out_index, 1);
      chk("stall_out_sample", int'(out_sample), 7);
      chk("stall_in_ready", in_ready, 0);
    end
    sync();
    out_ready = 1'b1;
    wait_idle();

    // base_valid mid-run aborts the run and beats a simultaneous token
    load_base(100);
    push(100, 0, 0);
    send_tok(1'b1, grc(2'b01, 4'd0, 6'd0), 1);
    send_tok(1'b1, grc(2'b00, 4'd0, 6'd0), 0);
    out_ready = 1'b0;
    send_tok(1'b0, run(8), 1);
    base_valid = 1'b1; base = 16'sd200;
    in_valid = 1'b1; in_type = 1'b1; in_data = grc(2'b01, 4'd0, 6'd0);
    @(negedge clk);
    chk("bv_prio_in_ready", in_ready, 0);
    sync();
    base_valid = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_index", out_index, 0);
    chk("abort_err", err, 0);
    sync();
    out_ready = 1'b1;
    push(200, 0, 0);
    send_tok(1'b1, grc(2'b01, 4'd0, 6'd0), 1);

    // reset mid-run
    load_base(300);
    push(300, 0, 0);
    send_tok(1'b1, grc(2'b01, 4'd0, 6'd0), 1);
    out_ready = 1'b0;
    send_tok(1'b0, run(5), 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_index", out_index, 0);
    chk("mrst_out_sample", int'(out_sample), 0);
    chk("mrst_in_ready", in_ready, 0);
    sync();
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_type = 1'b1; in_data = grc(2'b01, 4'd0, 6'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 0);
      chk("post_rst_out_valid", out_valid, 0);
      sync();
    end
    in_valid = 1'b0;
    load_base(9);
    push(9, 0, 0);
    send_tok(1'b1, grc(2'b01, 4'd0, 6'd0), 1);
    wait_idle();
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
